// File: rtl/traffic_pkg.sv
// Shared encodings and default intervals for the traffic interval timer.
// No logic; pure constants, state type and the interval clamp helper.
package traffic_pkg;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_RSVD = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int TICK_DIV_DEF = 100000000;
  localparam int CNT_W_DEF    = 4;
  localparam int T_BASE_DEF   = 6;
  localparam int T_EXT_DEF    = 3;
  localparam int T_YEL_DEF    = 2;

  // A zero-length interval would never expire; run it as one second instead.
  function automatic int clamp_interval(input int t);
    return (t < 1) ? 1 : t;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Seconds prescaler: tick is high on the last of every TICK_DIV enabled cycles.
// Latency: first tick TICK_DIV-1 cycles after clr/enable; no backpressure, clr wins over en.
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  if (TICK_DIV < 2) begin : g_bad_div
    $error("tick_prescaler: TICK_DIV must be at least 2");
  end

  logic [W-1:0] r_cnt;

  // Held at zero while disabled so every run starts a full tick period.
  always_ff @(posedge clock) begin
    if (!reset || clr || !en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/traffic_interval_timer.sv
// Interval timer + walk latch for traffic_light_fsm; expired fires N*TICK_DIV cycles after start.
// No backpressure: start always (re)loads; TRAFFIC_WALK_SYNC_EN adds a 2-flop walk synchronizer.
module traffic_interval_timer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int T_BASE   = T_BASE_DEF,
  parameter int T_EXT    = T_EXT_DEF,
  parameter int T_YEL    = T_YEL_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             walk,
  input  logic             walk_clr,
  output logic             busy,
  output logic             expired,
  output logic [CNT_W-1:0] sec_remaining,
  output logic             walk_req
);

  localparam int T_BASE_C = clamp_interval(T_BASE);
  localparam int T_EXT_C  = clamp_interval(T_EXT);
  localparam int T_YEL_C  = clamp_interval(T_YEL);

  if (T_BASE_C >= (1 << CNT_W) || T_EXT_C >= (1 << CNT_W) || T_YEL_C >= (1 << CNT_W)) begin : g_bad_interval
    $error("traffic_interval_timer: interval does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(T_BASE_C);
  localparam logic [CNT_W-1:0] LOAD_EXT  = CNT_W'(T_EXT_C);
  localparam logic [CNT_W-1:0] LOAD_YEL  = CNT_W'(T_YEL_C);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_load;
  logic             r_expired;
  logic             w_expired_nxt;
  logic             w_tick;
  logic             w_walk;
  logic             r_walk_req;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .clr   (start),
    .en    (r_state == ST_RUN),
    .tick  (w_tick)
  );

  always_comb begin
    case (sel)
      SEL_EXT:  w_load = LOAD_EXT;
      SEL_YEL:  w_load = LOAD_YEL;
      SEL_BASE,
      SEL_RSVD: w_load = LOAD_BASE;
      default:  w_load = LOAD_BASE;
    endcase
  end

  // start outranks the final tick, so a retrigger never produces a stale expiry.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_expired_nxt = 1'b0;
    if (start) begin
      w_state_nxt = ST_RUN;
      w_count_nxt = w_load;
    end else if (r_state == ST_RUN && w_tick) begin
      w_count_nxt = r_count - CNT_W'(1);
      if (r_count == CNT_W'(1)) begin
        w_state_nxt   = ST_IDLE;
        w_expired_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_expired <= w_expired_nxt;
    end
  end

`ifdef TRAFFIC_WALK_SYNC_EN
  logic r_walk_s1;
  logic r_walk_s2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_walk_s1 <= 1'b0;
      r_walk_s2 <= 1'b0;
    end else begin
      r_walk_s1 <= walk;
      r_walk_s2 <= r_walk_s1;
    end
  end

  assign w_walk = r_walk_s2;
`else
  assign w_walk = walk;
`endif

  // Set beats clear so a press coinciding with an acknowledge is not lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_walk_req <= 1'b0;
    end else if (w_walk) begin
      r_walk_req <= 1'b1;
    end else if (walk_clr) begin
      r_walk_req <= 1'b0;
    end
  end

  assign busy          = (r_state == ST_RUN);
  assign expired       = r_expired;
  assign sec_remaining = r_count;
  assign walk_req      = r_walk_req;

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Scoreboarded bench for traffic_interval_timer with TICK_DIV=4: directed plan then random traffic.
module tb_traffic_interval_timer;

  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       walk = 1'b0;
  logic       walk_clr = 1'b0;
  logic       busy;
  logic       expired;
  logic [3:0] sec_remaining;
  logic       walk_req;

  traffic_interval_timer #(
    .TICK_DIV (TD)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .sel           (sel),
    .walk          (walk),
    .walk_clr      (walk_clr),
    .busy          (busy),
    .expired       (expired),
    .sec_remaining (sec_remaining),
    .walk_req      (walk_req)
  );

  always #5 clock = ~clock;

  typedef struct {
    int e;
    bit busy;
    bit exp;
    int sec;
    bit wreq;
  } obs_t;

  obs_t cyc_q[$];
  int   exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;

  // Reference model state: interval described by its start edge and length.
  bit m_run = 0;
  int m_k = 0;
  int m_n = 0;
  bit m_wreq = 0;
  bit m_h1 = 0;
  bit m_h2 = 0;

  function automatic int t_of(input logic [1:0] s);
    case (s)
      2'd1:    return 3;
      2'd2:    return 2;
      default: return 6;
    endcase
  endfunction

  task automatic step(input bit rst_n, input bit st, input logic [1:0] sl,
                      input bit w, input bit wc);
    obs_t o;
    bit   w_eff;
    reset = rst_n; start = st; sel = sl; walk = w; walk_clr = wc;
    @(posedge clock);
    edge_cnt++;
    o.e = edge_cnt;
    o.exp = 1'b0;
    if (!rst_n) begin
      m_run = 0; m_wreq = 0; m_h1 = 0; m_h2 = 0;
    end else begin
      if (st) begin
        m_run = 1; m_k = edge_cnt; m_n = t_of(sl);
      end else if (m_run && (edge_cnt - m_k) == m_n * TD) begin
        m_run = 0;
        o.exp = 1'b1;
        exp_q.push_back(edge_cnt);
      end
`ifdef TRAFFIC_WALK_SYNC_EN
      w_eff = m_h2; m_h2 = m_h1; m_h1 = w;
`else
      w_eff = w;
`endif
      if (w_eff) m_wreq = 1;
      else if (wc) m_wreq = 0;
    end
    o.busy = m_run;
    o.sec  = m_run ? (m_n - (edge_cnt - m_k) / TD) : 0;
    o.wreq = m_wreq;
    cyc_q.push_back(o);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 2'd0, 0, 0);
  endtask

  // Monitor: per-cycle output check plus expiry-event scoreboard.
  always @(negedge clock) begin
    obs_t o;
    if (cyc_q.size() > 0) begin
      o = cyc_q.pop_front();
      checks++;
      if (busy !== o.busy || expired !== o.exp || int'(sec_remaining) != o.sec ||
          walk_req !== o.wreq || $isunknown({busy, expired, sec_remaining, walk_req})) begin
        errors++;
        $display("FAIL outputs @edge %0d: got busy=%b exp=%b sec=%0d wreq=%b want busy=%b exp=%b sec=%0d wreq=%b",
                 o.e, busy, expired, sec_remaining, walk_req, o.busy, o.exp, o.sec, o.wreq);
      end
    end
    if (expired === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL expiry @edge %0d: got unexpected pulse want none", edge_cnt);
      end else if (exp_q[0] != edge_cnt) begin
        errors++;
        $display("FAIL expiry edge: got %0d want %0d", edge_cnt, exp_q[0]);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    // Reset with start and walk held high.
    step(0, 1, 2'd0, 1, 0);
    step(0, 1, 2'd0, 1, 0);
    idle(3);
    // BASE, YEL, reserved select.
    step(1, 1, 2'd0, 0, 0); idle(27);
    step(1, 1, 2'd2, 0, 0); idle(10);
    step(1, 1, 2'd3, 0, 0); idle(27);
    // Retrigger at relative edge 10 with EXT.
    step(1, 1, 2'd0, 0, 0); idle(9);
    step(1, 1, 2'd1, 0, 0); idle(16);
    // Start coincident with the final tick.
    step(1, 1, 2'd0, 0, 0); idle(23);
    step(1, 1, 2'd2, 0, 0); idle(10);
    // Walk pulse, hold, clear, then set/clear together.
    step(1, 0, 2'd0, 1, 0); idle(5);
    step(1, 0, 2'd0, 0, 1); idle(2);
    step(1, 0, 2'd0, 1, 0); idle(3);
    step(1, 0, 2'd0, 1, 1); step(1, 0, 2'd0, 0, 0); idle(3);
    step(1, 0, 2'd0, 0, 1); idle(2);
    // Reset mid-interval at relative edge 10.
    step(1, 1, 2'd0, 1, 0); idle(9);
    step(0, 0, 2'd0, 0, 0); idle(25);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 19) == 0),
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0));
    end
    idle(30);
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0 || cyc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expiries and %0d cycles pending want 0 and 0",
               exp_q.size(), cyc_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_interval_timer.md
Name: traffic_interval_timer

Overview:
- Interval timer and request latch that sequences traffic_light_fsm.
- The FSM pulses `start` with an interval select. This block divides `clock` down to a seconds tick, counts the selected interval, and returns a one-cycle `expired` pulse.
- It also latches the pedestrian `walk` button until the FSM acknowledges it, so the FSM holds no timing counters of its own.

Parameters:
- TICK_DIV, 100000000: clock cycles per seconds tick; must be ≥2; benches use 4.
- CNT_W, 4: width of the seconds counter and `sec_remaining`.
- T_BASE, 6: base green interval, in seconds.
- T_EXT, 3: extended interval (sensor/walk), in seconds.
- T_YEL, 2: yellow interval, in seconds.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  load and run the selected interval; sampled at each rising edge.
- sel  in  2  interval select: 0=BASE, 1=EXT, 2=YEL, 3=reserved (treated as BASE).
- walk  in  1  raw pedestrian button, level.
- walk_clr  in  1  FSM acknowledge; clears `walk_req`.
- busy  out  1  high while an interval is running.
- expired  out  1  one-cycle pulse when an interval completes.
- sec_remaining  out  CNT_W  seconds left; 0 when idle.
- walk_req  out  1  latched walk request.

Behaviour:
- Reset:
  - Sampled only at a rising edge with reset==0.
  - Returns state to IDLE and clears the prescaler and counter.
  - All outputs are 0 after the edge: busy=0, expired=0, sec_remaining=0, walk_req=0.
  - Reset asserted mid-interval aborts the interval with no `expired` pulse.
- States: IDLE, RUN. `busy` = (state==RUN), registered.
- Start:
  - `start` at edge k, in any state, loads count=T(sel), clears the prescaler and enters RUN.
  - busy=1 and sec_remaining=T(sel) from edge k onward.
- Ticks:
  - The prescaler counts 0..TICK_DIV-1 while in RUN; tick = (prescaler==TICK_DIV-1).
  - Ticks occur at edges k+TICK_DIV, k+2·TICK_DIV, …
  - Each tick decrements the count.
- Expiry:
  - The tick taking the count from 1 to 0 (edge k+N·TICK_DIV, N=T(sel)) sets expired=1 for exactly one cycle and returns to IDLE with busy=0.
  - Total latency from the start edge to `expired` is N·TICK_DIV cycles.
- Retrigger: `start` while in RUN aborts the current interval (no `expired` for it) and reloads as above.
- Simultaneous `start` and final tick: start wins; expired=0 and the new interval loads.
- Interval values: T_* values of 0 are clamped to 1 at elaboration. Values wider than CNT_W are an elaboration error.
- IDLE: the prescaler is held at 0 and `start` is the only exit.
- Walk latch:
  - walk_req is set by walk==1 on any edge and cleared by walk_clr.
  - walk and walk_clr in the same cycle: set wins.
  - The latch operates in every state and is independent of the timer.

Optional Feature:
- Macro: TRAFFIC_WALK_SYNC_EN.
- Defined: `walk` passes through a 2-flop synchronizer before the latch, so walk_req rises 3 edges after walk rises.
- Undefined: `walk` is used directly and walk_req rises on the first edge with walk==1.

Decomposition:
- Package traffic_pkg holds:
  - sel encodings SEL_BASE=2'd0, SEL_EXT=2'd1, SEL_YEL=2'd2, SEL_RSVD=2'd3;
  - state encodings ST_IDLE and ST_RUN;
  - default interval constants.
- Sub-module tick_prescaler (parameter TICK_DIV):
  - inputs clock, reset, clr, en; output tick;
  - counter that wraps at TICK_DIV-1.
- The top level holds the FSM, the down-counter and the walk latch.

Test Plan (TICK_DIV=4, defaults otherwise):
- Reset: drive reset=0 for 2 edges with start=1 and walk=1 -> busy, expired, sec_remaining and walk_req all 0; after release, outputs stay 0 until start.
- BASE: start=1, sel=0 at edge 0 ->
  - busy=1 and sec_remaining=6 from edge 0;
  - sec_remaining 5,4,3,2,1 at edges 4,8,12,16,20;
  - expired=1 only at edge 24, where busy falls to 0.
- YEL and reserved select: sel=2 -> expired at edge 8 only; sel=3 -> expired at edge 24, identical to BASE.
- Retrigger: start sel=0 at edge 0, then start sel=1 at edge 10 -> no pulse at edge 24; expired at edge 22; sec_remaining=3 at edge 10.
- Simultaneous: start asserted on the edge-24 final tick -> expired stays 0, busy stays 1, new interval runs.
- Walk:
  - a 1-cycle walk pulse -> walk_req=1 next edge (3 edges with TRAFFIC_WALK_SYNC_EN), held until walk_clr;
  - walk and walk_clr together -> walk_req stays 1;
  - reset=0 mid-interval at edge 10 -> all outputs 0 at edge 11 and no expired afterwards.
